itf2reg_burst: RTL

Parametrised successor of the byte-wide indirect register bridge. It maps an 8-bit ITF address/data port onto a multi-byte register bus with configurable address and data widths. Each access is a handshake: a one-cycle reg_ce request, then a wait for reg_fin, bounded by a timeout counter. It adds a STATUS register (busy/done/error), read-data capture on completion, and optional address auto-increment for burst sequences.

---
 rtl/itf2reg_pkg.sv | 33 +++
 rtl/itf_byte_bank.sv | 43 ++++
 rtl/itf2reg_burst.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/itf2reg_pkg.sv
// rtl/itf2reg_pkg.sv - shared address map, bit indices and FSM encoding for itf2reg_burst
//
// Purpose : constants shared by the ITF-to-register burst bridge and its byte banks.
// Ports   : none (package).

package itf2reg_pkg;

   // ITF address map
   localparam logic [7:0] STATUS        = 8'h00;
   localparam logic [7:0] OPERATION     = 8'h01;
   localparam logic [7:0] ADDR_BASE     = 8'h10;
   localparam logic [7:0] WDATA_BASE    = 8'h20;
   localparam logic [7:0] RDATA_BASE    = 8'h30;
   localparam logic [7:0] DEFAULT_RDATA = 8'hAB;

   // STATUS bits
   localparam int ST_DONE_BIT   = 0;
   localparam int ST_BUSY_BIT   = 1;
   localparam int ST_TOERR_BIT  = 2;
   localparam int ST_LASTWR_BIT = 3;

   // OPERATION bits
   localparam int OP_WE_BIT   = 0;
   localparam int OP_GO_BIT   = 1;
   localparam int OP_AINC_BIT = 2;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2
   } state_t;

endpackage

// File: rtl/itf_byte_bank.sv
// rtl/itf_byte_bank.sv - N-byte register written one byte at a time over the ITF port
//
// Purpose : holds a multi-byte value whose byte i sits at ITF address BASE+i.
// Ports   : clk, rst_n   - clock, asynchronous active-low reset
//           wr, addr,     - ITF write strobe, address and data
//           wdata
//           inhibit       - blocks ITF writes (bridge busy)
//           load,         - whole-word load, takes priority over ITF writes
//           load_data
//           q             - current register value

module itf_byte_bank
   import itf2reg_pkg::*;
#(
   parameter int         NBYTES = 2,
   parameter logic [7:0] BASE   = ADDR_BASE
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                wr,
   input  logic [7:0]          addr,
   input  logic [7:0]          wdata,
   input  logic                inhibit,
   input  logic                load,
   input  logic [8*NBYTES-1:0] load_data,
   output logic [8*NBYTES-1:0] q
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q <= '0;
      end else if (load) begin
         q <= load_data;
      end else if (wr && !inhibit) begin
         for (int i = 0; i < NBYTES; i++) begin
            if (addr == BASE + 8'(i)) begin
               q[8*i +: 8] <= wdata;
            end
         end
      end
   end

endmodule

// File: rtl/itf2reg_burst.sv
// rtl/itf2reg_burst.sv - byte-wide ITF port to multi-byte register bus bridge with burst support
//
// Purpose : turns ITF byte accesses into single reg_ce handshakes on a wide
//           register bus, with status, read-data capture, timeout and
//           optional address auto-increment.
// Ports   : clk, rst_n        - clock, asynchronous active-low reset
//           itf_addr/wdata/wr - ITF write side
//           itf_rdata         - ITF read data (combinational on itf_addr)
//           reg_fin, reg_rdata- slave completion pulse and read data
//           reg_addr, reg_ce, - register bus request
//           reg_we, reg_wdata

module itf2reg_burst
   import itf2reg_pkg::*;
#(
   parameter int ADDR_BYTES = 2,
   parameter int DATA_BYTES = 4,
   parameter int TIMEOUT    = 255
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [7:0]              itf_addr,
   input  logic [7:0]              itf_wdata,
   input  logic                    itf_wr,
   output logic [7:0]              itf_rdata,
   input  logic                    reg_fin,
   input  logic [8*DATA_BYTES-1:0] reg_rdata,
   output logic [8*ADDR_BYTES-1:0] reg_addr,
   output logic                    reg_ce,
   output logic                    reg_we,
   output logic [8*DATA_BYTES-1:0] reg_wdata
);

   localparam int AW = 8*ADDR_BYTES;
   localparam int DW = 8*DATA_BYTES;
   // With the timeout disabled a 1-bit counter is kept so the logic stays legal; it never runs.
   localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT+1) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT-1 : 0);

   state_t        state, state_nxt;
   logic          op_we, op_ainc;
   logic          st_done, st_toerr, st_lastwr;
   logic [DW-1:0] rdata_q;
   logic [CW-1:0] to_cnt;

   logic          busy, wr_status, wr_op, go, fin_evt, to_evt, addr_inc;
   logic [AW-1:0] addr_q, addr_nxt;
   logic [DW-1:0] wdata_q;
   logic [7:0]    status_byte, op_byte;

   assign busy      = (state != IDLE);
   assign wr_status = itf_wr && (itf_addr == STATUS);
   // OPERATION is frozen while an access is in flight, GO included.
   assign wr_op     = itf_wr && (itf_addr == OPERATION) && !busy;
   assign go        = wr_op && itf_wdata[OP_GO_BIT];
   // reg_fin counts from the REQ cycle on, so a zero-wait slave completes in REQ.
   assign fin_evt   = busy && reg_fin;
   assign to_evt    = (TIMEOUT > 0) && (state == WAIT) && !reg_fin && (to_cnt == CNT_LAST);
   assign addr_inc  = fin_evt && op_ainc;
   assign addr_nxt  = addr_q + AW'(1);

   itf_byte_bank #(.NBYTES(ADDR_BYTES), .BASE(ADDR_BASE)) u_addr_bank (
      .clk       (clk),
      .rst_n     (rst_n),
      .wr        (itf_wr),
      .addr      (itf_addr),
      .wdata     (itf_wdata),
      .inhibit   (busy),
      .load      (addr_inc),
      .load_data (addr_nxt),
      .q         (addr_q)
   );

   itf_byte_bank #(.NBYTES(DATA_BYTES), .BASE(WDATA_BASE)) u_wdata_bank (
      .clk       (clk),
      .rst_n     (rst_n),
      .wr        (itf_wr),
      .addr      (itf_addr),
      .wdata     (itf_wdata),
      .inhibit   (busy),
      .load      (1'b0),
      .load_data ('0),
      .q         (wdata_q)
   );

   assign reg_addr  = addr_q;
   assign reg_wdata = wdata_q;

   always_comb begin
      state_nxt = state;
      reg_ce    = 1'b0;
      reg_we    = 1'b0;
      case (state)
         IDLE: begin
            if (go) state_nxt = REQ;
         end
         REQ: begin
            reg_ce    = 1'b1;
            reg_we    = op_we;
            state_nxt = reg_fin ? IDLE : WAIT;
         end
         WAIT: begin
            if (reg_fin || to_evt) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         op_we     <= 1'b0;
         op_ainc   <= 1'b0;
         st_done   <= 1'b0;
         st_toerr  <= 1'b0;
         st_lastwr <= 1'b0;
         rdata_q   <= '0;
         to_cnt    <= '0;
      end else begin
         state <= state_nxt;

         if (wr_op) begin
            op_we   <= itf_wdata[OP_WE_BIT];
            op_ainc <= itf_wdata[OP_AINC_BIT];
         end

         if (state == REQ) begin
            to_cnt <= '0;
         end else if ((state == WAIT) && (TIMEOUT > 0)) begin
            to_cnt <= to_cnt + CW'(1);
         end

         // Hardware set has priority over a same-cycle W1C clear.
         if (fin_evt || to_evt) begin
            st_done <= 1'b1;
         end else if (wr_status && itf_wdata[ST_DONE_BIT]) begin
            st_done <= 1'b0;
         end

         if (to_evt) begin
            st_toerr <= 1'b1;
         end else if (wr_status && itf_wdata[ST_TOERR_BIT]) begin
            st_toerr <= 1'b0;
         end

         if (fin_evt) begin
            st_lastwr <= op_we;
            if (!op_we) rdata_q <= reg_rdata;
         end
      end
   end

   always_comb begin
      status_byte                = 8'h00;
      status_byte[ST_DONE_BIT]   = st_done;
      status_byte[ST_BUSY_BIT]   = busy;
      status_byte[ST_TOERR_BIT]  = st_toerr;
      status_byte[ST_LASTWR_BIT] = st_lastwr;

      op_byte              = 8'h00;
      op_byte[OP_WE_BIT]   = op_we;
      op_byte[OP_AINC_BIT] = op_ainc;
   end

   always_comb begin
      itf_rdata = DEFAULT_RDATA;
      if (itf_addr == STATUS)    itf_rdata = status_byte;
      if (itf_addr == OPERATION) itf_rdata = op_byte;
      for (int i = 0; i < ADDR_BYTES; i++) begin
         if (itf_addr == ADDR_BASE + 8'(i)) itf_rdata = addr_q[8*i +: 8];
      end
      for (int i = 0; i < DATA_BYTES; i++) begin
         if (itf_addr == WDATA_BASE + 8'(i)) itf_rdata = wdata_q[8*i +: 8];
         if (itf_addr == RDATA_BASE + 8'(i)) itf_rdata = rdata_q[8*i +: 8];
      end
   end

endmodule
